eth_frame_player: RTL and testbench

- Synthesizable, parametrised stimulus engine that replays a scripted sequence of Ethernet frames onto the eth_rx_* byte interface of the IP core under test.
- Successor to the hand-coded send-state machine: frames come from a loadable script memory with per-frame good/bad status, optional expected-answer tracking with timeout, and configurable gaps.
- Sits between the bench or host loader and the core's RX side. Passively monitors the core's eth_tx_data_en.

---
 rtl/eth_frame_player.sv | 136 +++++++++++++
 tb/tb_eth_frame_player.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_player.sv
// Scripted Ethernet RX stimulus engine: replays frames from a loadable script
// memory onto the eth_rx_* byte interface and tracks answers on eth_tx_data_en.
module eth_frame_player #(
  parameter int MEM_DEPTH  = 2048,
  parameter int ADDR_W     = 11,
  parameter int STATUS_GAP = 4,
  parameter int IFG        = 12,
  parameter int TIMEOUT    = 4096,
  parameter int MAX_LEN    = 1536
) (
  input  logic              eth_rx_clk,
  input  logic              eth_rx_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [10:0]       wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        n_frames,
  input  logic              eth_tx_data_en,
  output logic [7:0]        eth_rx_data,
  output logic              eth_rx_data_valid,
  output logic              eth_rx_frame_good,
  output logic              eth_rx_frame_bad,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frames_sent,
  output logic [7:0]        answers_seen,
  output logic              timeout_err,
  output logic              len_err
);
  localparam int MAX_A   = (TIMEOUT > MAX_LEN) ? TIMEOUT : MAX_LEN;
  localparam int MAX_B   = (IFG > STATUS_GAP) ? IFG : STATUS_GAP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_STREAM, S_SGAP, S_STATUS,
    S_WAIT_ANS, S_WAIT_END, S_IFG_WAIT, S_FIN
  } state_t;

  state_t            state, state_next;
  logic [10:0]       mem [MEM_DEPTH];
  logic [10:0]       q;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        nf;
  logic [CNT_W-1:0]  cnt;
  logic              forced;
  logic [2:0]        tx_sync;
  logic              ren, last_byte, bad_eff, ans_eff, tx_rise;

  always_ff @(posedge eth_rx_clk)
    if (wr_en && state == S_IDLE) mem[wr_addr] <= wr_data;

  // q keeps the frame's last word after STREAM, so data holds and flags stay readable
  always_ff @(posedge eth_rx_clk or negedge eth_rx_rst_n)
    if (!eth_rx_rst_n) q <= '0;
    else if (ren)      q <= mem[addr];

  always_comb begin
    state_next = state;
    ren        = 1'b0;
    last_byte  = q[8] || (cnt == CNT_W'(MAX_LEN - 1));
    bad_eff    = forced || q[9];
    ans_eff    = !forced && q[10];
    tx_rise    = tx_sync[1] && !tx_sync[2];
    case (state)
      S_IDLE:     if (start) state_next = (n_frames == 8'd0) ? S_FIN : S_FETCH;
      S_FETCH: begin
        ren        = 1'b1;
        state_next = S_STREAM;
      end
      S_STREAM:   if (last_byte) state_next = S_SGAP;
                  else ren = 1'b1;
      S_SGAP:     if (cnt == CNT_W'(STATUS_GAP - 1)) state_next = S_STATUS;
      S_STATUS:   state_next = ans_eff ? S_WAIT_ANS : S_IFG_WAIT;
      S_WAIT_ANS: if (tx_rise) state_next = S_WAIT_END;
                  else if (cnt == CNT_W'(TIMEOUT - 1)) state_next = S_IFG_WAIT;
      S_WAIT_END: if (!tx_sync[1]) state_next = S_IFG_WAIT;
      S_IFG_WAIT: if (cnt == CNT_W'(IFG - 1))
                    state_next = (frames_sent < nf) ? S_FETCH : S_FIN;
      S_FIN:      state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge eth_rx_clk or negedge eth_rx_rst_n) begin
    if (!eth_rx_rst_n) begin
      state        <= S_IDLE;
      addr         <= '0;
      nf           <= '0;
      cnt          <= '0;
      forced       <= 1'b0;
      tx_sync      <= '0;
      frames_sent  <= '0;
      answers_seen <= '0;
      timeout_err  <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      state   <= state_next;
      tx_sync <= {tx_sync[1:0], eth_tx_data_en};
      // one shared counter, restarted on every state change
      cnt     <= (state_next != state || state == S_IDLE) ? '0 : cnt + 1'b1;
      if (ren) addr <= addr + 1'b1;
      case (state)
        S_IDLE: if (start) begin
          addr         <= base_addr;
          nf           <= n_frames;
          frames_sent  <= '0;
          answers_seen <= '0;
          timeout_err  <= 1'b0;
          len_err      <= 1'b0;
        end
        S_STREAM: if (last_byte) begin
          forced <= !q[8];
          if (!q[8]) len_err <= 1'b1;
        end
        S_STATUS: if (frames_sent != 8'hFF) frames_sent <= frames_sent + 8'd1;
        S_WAIT_ANS: begin
          if (tx_rise) begin
            if (answers_seen != 8'hFF) answers_seen <= answers_seen + 8'd1;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign eth_rx_data       = q[7:0];
  assign eth_rx_data_valid = (state == S_STREAM);
  assign eth_rx_frame_good = (state == S_STATUS) && !bad_eff;
  assign eth_rx_frame_bad  = (state == S_STATUS) && bad_eff;
  assign busy              = (state != S_IDLE);
  assign done              = (state == S_FIN);
endmodule

// File: tb/tb_eth_frame_player.sv
// Self-checking bench for eth_frame_player: table rows, hand sequences and
// randomized scripts checked against a frame-level model of the script memory.
module tb_eth_frame_player;
  localparam int MEM_DEPTH = 2048, ADDR_W = 11, STATUS_GAP = 4, IFG = 12;
  localparam int TIMEOUT = 4096, MAX_LEN = 1536, RESP_DELAY = 30;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, start = 1'b0, tx_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, base_addr = '0;
  logic [10:0] wr_data = '0;
  logic [7:0] n_frames = '0;
  logic [7:0] rx_data, frames_sent, answers_seen;
  logic rx_valid, frame_good, frame_bad, busy, done, timeout_err, len_err;

  eth_frame_player #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .STATUS_GAP(STATUS_GAP),
                     .IFG(IFG), .TIMEOUT(TIMEOUT), .MAX_LEN(MAX_LEN)) dut (
    .eth_rx_clk(clk), .eth_rx_rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .base_addr(base_addr), .n_frames(n_frames),
    .eth_tx_data_en(tx_en), .eth_rx_data(rx_data), .eth_rx_data_valid(rx_valid),
    .eth_rx_frame_good(frame_good), .eth_rx_frame_bad(frame_bad), .busy(busy),
    .done(done), .frames_sent(frames_sent), .answers_seen(answers_seen),
    .timeout_err(timeout_err), .len_err(len_err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [10:0] ref_mem [MEM_DEPTH];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: collects streamed bytes, frame lengths, status pulses and their gap
  int cyc = 0, last_valid_cyc = 0, run_len = 0, done_cnt = 0, both_cnt = 0;
  logic [7:0] rx_q[$];
  int len_q[$], gap_q[$];
  bit bad_q[$];
  always @(negedge clk) begin
    cyc++;
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      run_len++;
      last_valid_cyc = cyc;
    end else if (run_len != 0) begin
      len_q.push_back(run_len);
      run_len = 0;
    end
    if (frame_good || frame_bad) begin
      bad_q.push_back(frame_bad);
      gap_q.push_back(cyc - last_valid_cyc);
      if (frame_good && frame_bad) both_cnt++;
    end
    if (done) done_cnt++;
  end

  // Responder: per status pulse, optionally raise tx_en RESP_DELAY cycles later
  bit resp_plan[$];
  int resp_cnt = 0, resp_hold = 0;
  always @(negedge clk) begin
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin tx_en = 1'b1; resp_hold = 8; end
    end else if (resp_hold > 0) begin
      resp_hold--;
      if (resp_hold == 0) tx_en = 1'b0;
    end
    if ((frame_good || frame_bad) && resp_plan.size() != 0)
      if (resp_plan.pop_front()) resp_cnt = RESP_DELAY;
  end

  task automatic clear_mon();
    rx_q.delete(); len_q.delete(); gap_q.delete(); bad_q.delete();
    run_len = 0; done_cnt = 0; both_cnt = 0;
  endtask

  // len==0 writes a script with no last marker
  task automatic build(input logic [ADDR_W-1:0] base, input int len, input bit bad,
                       input bit expa, output logic [ADDR_W-1:0] nxt);
    logic [ADDR_W-1:0] a;
    logic [10:0] w;
    int words;
    a = base;
    words = (len == 0) ? MAX_LEN + 2 : len;
    for (int i = 0; i < words; i++) begin
      w = {2'($urandom), 1'b0, 8'($urandom)};
      if (len != 0 && i == words - 1) w[10:8] = {expa, bad, 1'b1};
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = w;
      ref_mem[a] = w;
      a = a + 1'b1;
    end
    @(negedge clk);
    wr_en = 1'b0;
    nxt = a;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int b;
    b = budget;
    while (!done && b > 0) begin @(negedge clk); b--; end
    check({tag, " done seen"}, int'(done), 1);
    @(negedge clk);
    check({tag, " busy after done"}, int'(busy), 0);
    repeat (60) @(negedge clk);
  endtask

  task automatic play(input logic [ADDR_W-1:0] base, input logic [7:0] n, input string tag);
    @(negedge clk);
    base_addr = base; n_frames = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n != 8'd0) begin
      check({tag, " fetch cycle valid"}, int'(rx_valid), 0);
      @(negedge clk);
      check({tag, " first byte valid"}, int'(rx_valid), 1);
    end else begin
      check({tag, " done 1 cycle after start"}, int'(done), 1);
    end
    wait_done(tag, int'(n) * (MAX_LEN + TIMEOUT + 200) + 100);
  endtask

  // Model: walk the script frame by frame and compare what the monitor saw
  task automatic run_check(input string tag, input logic [ADDR_W-1:0] base,
                           input int n, input bit [7:0] resp);
    logic [7:0] eb[$];
    int el[$];
    bit ebad[$];
    logic [ADDR_W-1:0] a;
    logic [10:0] w;
    int len, exp_ans, byte_err;
    bit forced, exp_to, exp_le;
    a = base; exp_ans = 0; exp_to = 0; exp_le = 0; byte_err = 0;
    for (int f = 0; f < n; f++) begin
      len = 0;
      do begin
        w = ref_mem[a];
        eb.push_back(w[7:0]);
        len++;
        a = a + 1'b1;
      end while (!w[8] && len < MAX_LEN);
      forced = !w[8];
      el.push_back(len);
      ebad.push_back(forced || w[9]);
      if (!forced && w[10]) begin
        if (resp[f]) exp_ans++;
        else exp_to = 1'b1;
      end
      if (forced) exp_le = 1'b1;
    end
    clear_mon();
    resp_plan.delete();
    for (int f = 0; f < n; f++) resp_plan.push_back(resp[f]);
    play(base, n[7:0], tag);
    check({tag, " frame count"}, len_q.size(), n);
    check({tag, " status count"}, bad_q.size(), n);
    for (int f = 0; f < n && f < len_q.size(); f++)
      check($sformatf("%s len[%0d]", tag, f), len_q[f], el[f]);
    for (int f = 0; f < n && f < bad_q.size(); f++) begin
      check($sformatf("%s bad[%0d]", tag, f), int'(bad_q[f]), int'(ebad[f]));
      check($sformatf("%s status gap[%0d]", tag, f), gap_q[f], STATUS_GAP + 1);
    end
    check({tag, " byte count"}, rx_q.size(), eb.size());
    for (int i = 0; i < rx_q.size() && i < eb.size(); i++)
      if (rx_q[i] != eb[i]) byte_err++;
    check({tag, " byte mismatches"}, byte_err, 0);
    check({tag, " frames_sent"}, int'(frames_sent), n);
    check({tag, " answers_seen"}, int'(answers_seen), exp_ans);
    check({tag, " timeout_err"}, int'(timeout_err), int'(exp_to));
    check({tag, " len_err"}, int'(len_err), int'(exp_le));
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " good and bad together"}, both_cnt, 0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    int len; bit bad; bit expa; bit resp;
    int exp_len; bit exp_bad; int exp_ans; bit exp_to; bit exp_le;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] nxt;
    int budget;
    tbl[0] = '{11'd0,    42, 1'b0, 1'b1, 1'b1, 42,      1'b0, 1, 1'b0, 1'b0};
    tbl[1] = '{11'd300,  10, 1'b1, 1'b0, 1'b1, 10,      1'b1, 0, 1'b0, 1'b0};
    tbl[2] = '{11'd2045,  6, 1'b0, 1'b0, 1'b0, 6,       1'b0, 0, 1'b0, 1'b0};
    tbl[3] = '{11'd500,   1, 1'b0, 1'b0, 1'b0, 1,       1'b0, 0, 1'b0, 1'b0};
    tbl[4] = '{11'd700,   8, 1'b1, 1'b1, 1'b1, 8,       1'b1, 1, 1'b0, 1'b0};
    tbl[5] = '{11'd900,  20, 1'b0, 1'b1, 1'b0, 20,      1'b0, 0, 1'b1, 1'b0};
    tbl[6] = '{11'd100,   0, 1'b0, 1'b1, 1'b1, MAX_LEN, 1'b1, 0, 1'b0, 1'b1};

    #12;
    check("reset valid", int'(rx_valid), 0);
    check("reset data", int'(rx_data), 0);
    check("reset busy/done", int'({busy, done}), 0);
    check("reset status", int'({frame_good, frame_bad}), 0);
    check("reset counters", int'({frames_sent, answers_seen}), 0);
    check("reset errors", int'({timeout_err, len_err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      build(tbl[r].base, tbl[r].len, tbl[r].bad, tbl[r].expa, nxt);
      run_check($sformatf("tbl%0d", r), tbl[r].base, 1, {7'd0, tbl[r].resp});
      check($sformatf("tbl%0d exp len", r), (len_q.size() != 0) ? len_q[0] : -1, tbl[r].exp_len);
      check($sformatf("tbl%0d exp bad", r), (bad_q.size() != 0) ? int'(bad_q[0]) : -1,
            int'(tbl[r].exp_bad));
      check($sformatf("tbl%0d exp answers", r), int'(answers_seen), tbl[r].exp_ans);
      check($sformatf("tbl%0d exp timeout", r), int'(timeout_err), int'(tbl[r].exp_to));
      check($sformatf("tbl%0d exp len_err", r), int'(len_err), int'(tbl[r].exp_le));
    end

    // Two frames back to back, only the first expects (and gets) an answer
    build(11'd200, 42, 1'b0, 1'b1, nxt);
    build(nxt, 50, 1'b0, 1'b0, nxt);
    run_check("two_frames", 11'd200, 2, 8'b01);
    check("two_frames answers", int'(answers_seen), 1);

    // Unanswered frame times out, playback still moves on to the next frame
    build(11'd1000, 20, 1'b0, 1'b1, nxt);
    build(nxt, 15, 1'b1, 1'b0, nxt);
    run_check("timeout_cont", 11'd1000, 2, 8'b00);
    check("timeout_cont timeout_err", int'(timeout_err), 1);

    // n_frames = 0
    clear_mon();
    play(11'd0, 8'd0, "zero_frames");
    check("zero_frames valid cycles", len_q.size() + rx_q.size(), 0);
    check("zero_frames done pulses", done_cnt, 1);

    // start and a script write while busy are both dropped
    build(11'd1200, 30, 1'b0, 1'b0, nxt);
    clear_mon();
    resp_plan.delete();
    @(negedge clk);
    base_addr = 11'd1200; n_frames = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    base_addr = 11'd1500; n_frames = 8'd3; start = 1'b1;
    wr_en = 1'b1; wr_addr = 11'd1205; wr_data = 11'h7FF;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_done("busy_start", 400);
    check("busy_start frames", len_q.size(), 1);
    check("busy_start frames_sent", int'(frames_sent), 1);
    check("busy_start done pulses", done_cnt, 1);
    run_check("busy_write_replay", 11'd1200, 1, 8'b0);

    // Asynchronous reset in the middle of a frame
    build(11'd1300, 100, 1'b0, 1'b0, nxt);
    clear_mon();
    @(negedge clk);
    base_addr = 11'd1300; n_frames = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre-reset streaming", int'(rx_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset valid", int'(rx_valid), 0);
    check("mid reset busy", int'(busy), 0);
    check("mid reset frames_sent", int'(frames_sent), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid reset status pulses", bad_q.size(), 0);
    run_check("after_reset_replay", 11'd1300, 1, 8'b0);

    // Randomized multi-frame scripts, every expecting frame answered
    for (int it = 0; it < 3; it++) begin
      logic [ADDR_W-1:0] b, a;
      int n;
      bit [7:0] resp;
      bit e;
      b = 11'($urandom);
      a = b;
      n = 1 + int'($urandom_range(3, 0));
      resp = '0;
      for (int f = 0; f < n; f++) begin
        e = 1'($urandom);
        resp[f] = e;
        build(a, 1 + int'($urandom_range(59, 0)), 1'($urandom), e, a);
      end
      budget = it;
      run_check($sformatf("rand%0d", budget), b, n, resp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
